// File: rtl/optimsoc_config_readback_if.sv
// ---------------------------------------------------------------------------
// optimsoc_config_readback_if
//
// Bundles the two access paths of the configuration readback block:
//   Wishbone slave side : wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[7:0] (in)
//                         wb_dat_o[31:0], wb_ack_o, wb_err_o         (out)
//   Dump stream side    : dump_start, out_ready                      (in)
//                         dump_busy, out_valid, out_data[31:0],
//                         out_last                                   (out)
// Directions above are as seen from the responder (modport slave).
// modport master is the requester / stream sink view.
// ---------------------------------------------------------------------------
interface optimsoc_config_readback_if;
  // Wishbone slave port
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  // Register-image dump stream
  logic        dump_start;
  logic        dump_busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    input  dump_start, out_ready,
    output dump_busy, out_valid, out_data, out_last
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    output dump_start, out_ready,
    input  dump_busy, out_valid, out_data, out_last
  );
endinterface

// File: rtl/optimsoc_config_readback.sv
// ---------------------------------------------------------------------------
// optimsoc_config_pkg / optimsoc_config_readback
//
// Read-only responder for the static system configuration. The derived
// config_t struct (parameter CONFIG) plus the tile index (parameter TILEID)
// are flattened into a 64-word register image. The image is exposed:
//   - to software through a Wishbone slave (reads ack, writes err), and
//   - to the debug infrastructure as a 64-word valid/ready burst that is
//     started by a single-cycle dump_start pulse.
// Both paths share the decode function but operate independently.
//
// Ports:
//   clk  (in)  : single clock
//   rst  (in)  : asynchronous, active-high reset
//   bus  (if)  : optimsoc_config_readback_if.slave, carrying the Wishbone
//                signals and the dump stream signals
//
// Register map (byte offset, word index = addr[7:2]):
//   0x00 VERSION  0x04 TILEID  0x08 NUMTILES  0x0C NUMCTS
//   0x10 CORES_PER_TILE  0x14 GMEM_SIZE  0x18 GMEM_TILE  0x1C LMEM_SIZE
//   0x20 TOTAL_NUM_CORES  0x24 FLAGS  0x28 DM_BASE  0x2C DM_SIZE
//   0x30 PGAS_BASE  0x34 PGAS_SIZE  0x38 NA_DMA_ENTRIES  0x3C DEBUG_NUM_MODS
//   0x40-0x7C reserved (0)  0x80-0xFC CTLIST pairs
// ---------------------------------------------------------------------------
package optimsoc_config_pkg;

  typedef enum logic [0:0] {
    PLAIN    = 1'b0,
    EXTERNAL = 1'b1
  } lmem_style_t;

  // Derived system configuration. All numeric fields are 32 bit so that
  // they map onto register words by plain zero-extension.
  typedef struct packed {
    logic [31:0]        NUMTILES;
    logic [31:0]        NUMCTS;
    logic [63:0][15:0]  CTLIST;
    logic [31:0]        CORES_PER_TILE;
    logic [31:0]        GMEM_SIZE;
    logic [31:0]        GMEM_TILE;
    logic               NOC_ENABLE_VCHANNELS;
    logic [31:0]        LMEM_SIZE;
    lmem_style_t        LMEM_STYLE;
    logic               ENABLE_BOOTROM;
    logic               ENABLE_DM;
    logic [31:0]        DM_BASE;
    logic [31:0]        DM_SIZE;
    logic               ENABLE_PGAS;
    logic [31:0]        PGAS_BASE;
    logic [31:0]        PGAS_SIZE;
    logic               NA_ENABLE_MPSIMPLE;
    logic               NA_ENABLE_DMA;
    logic               NA_DMA_GENIRQ;
    logic [31:0]        NA_DMA_ENTRIES;
    logic               USE_DEBUG;
    logic               DEBUG_STM;
    logic               DEBUG_CTM;
    logic [31:0]        DEBUG_NUM_MODS;
    logic [31:0]        TOTAL_NUM_CORES;
  } config_t;

endpackage

module optimsoc_config_readback
  import optimsoc_config_pkg::*;
#(
  parameter config_t     CONFIG = 'x,
  parameter int unsigned TILEID = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  optimsoc_config_readback_if.slave     bus
);

  localparam logic [31:0] VERSION   = 32'h0000_0001;
  localparam logic [5:0]  LAST_WORD = 6'd63;

  // Feature flags word; bits above 10 read as zero.
  localparam logic [31:0] FLAGS = {
    21'b0,
    (CONFIG.LMEM_STYLE == PLAIN),
    CONFIG.DEBUG_CTM,
    CONFIG.DEBUG_STM,
    CONFIG.USE_DEBUG,
    CONFIG.NA_DMA_GENIRQ,
    CONFIG.NA_ENABLE_DMA,
    CONFIG.NA_ENABLE_MPSIMPLE,
    CONFIG.ENABLE_PGAS,
    CONFIG.ENABLE_DM,
    CONFIG.ENABLE_BOOTROM,
    CONFIG.NOC_ENABLE_VCHANNELS
  };

  // -------------------------------------------------------------------------
  // Register image: pure function of the word index.
  // Upper half (idx[5]=1) packs two CTLIST entries per word, even entry low.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] f_decode(input logic [5:0] idx);
    logic [31:0] word;
    word = '0;
    if (idx[5]) begin
      word = {CONFIG.CTLIST[{idx[4:0], 1'b1}], CONFIG.CTLIST[{idx[4:0], 1'b0}]};
    end else begin
      case (idx[4:0])
        5'd0:    word = VERSION;
        5'd1:    word = 32'(TILEID);
        5'd2:    word = CONFIG.NUMTILES;
        5'd3:    word = CONFIG.NUMCTS;
        5'd4:    word = CONFIG.CORES_PER_TILE;
        5'd5:    word = CONFIG.GMEM_SIZE;
        5'd6:    word = CONFIG.GMEM_TILE;
        5'd7:    word = CONFIG.LMEM_SIZE;
        5'd8:    word = CONFIG.TOTAL_NUM_CORES;
        5'd9:    word = FLAGS;
        5'd10:   word = CONFIG.DM_BASE;
        5'd11:   word = CONFIG.DM_SIZE;
        5'd12:   word = CONFIG.PGAS_BASE;
        5'd13:   word = CONFIG.PGAS_SIZE;
        5'd14:   word = CONFIG.NA_DMA_ENTRIES;
        5'd15:   word = CONFIG.DEBUG_NUM_MODS;
        default: word = '0;  // 0x40-0x7C reserved
      endcase
    end
    return word;
  endfunction

  // The image is constant, so it elaborates to a 64-entry lookup table that
  // both access paths index into.
  logic [31:0] w_image [64];

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_image
      assign w_image[gi] = f_decode(6'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Wishbone responder
  // -------------------------------------------------------------------------
  logic        r_wb_ack;
  logic        r_wb_err;
  logic [31:0] r_wb_dat;
  logic [5:0]  w_wb_word;
  logic        w_wb_req;

  // Byte-lane bits [1:0] are dropped by the shift.
  assign w_wb_word = 6'(bus.wb_adr_i >> 2);

  // A request is only taken while no response is outstanding; this is what
  // forces a held strobe into ack-on-alternate-cycles.
  assign w_wb_req = bus.wb_cyc_i & bus.wb_stb_i & ~r_wb_ack & ~r_wb_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_ack <= 1'b0;
      r_wb_err <= 1'b0;
      r_wb_dat <= '0;
    end else if (w_wb_req) begin
      r_wb_ack <= ~bus.wb_we_i;
      r_wb_err <= bus.wb_we_i;
      r_wb_dat <= bus.wb_we_i ? 32'd0 : w_image[w_wb_word];
    end else begin
      r_wb_ack <= 1'b0;
      r_wb_err <= 1'b0;
      r_wb_dat <= '0;
    end
  end

  assign bus.wb_ack_o = r_wb_ack;
  assign bus.wb_err_o = r_wb_err;
  assign bus.wb_dat_o = r_wb_dat;

  // -------------------------------------------------------------------------
  // Dump state machine
  // -------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [5:0] r_index;
  logic [5:0] w_index_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  // Next-state logic. dump_start is only looked at in IDLE, so a pulse on
  // the final handshake edge (still in SEND) is dropped.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    case (r_state)
      S_IDLE: begin
        if (bus.dump_start) begin
          w_state_next = S_SEND;
          w_index_next = '0;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (r_index == LAST_WORD) begin
            w_state_next = S_IDLE;
            w_index_next = '0;
          end else begin
            w_index_next = r_index + 6'd1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_index_next = '0;
      end
    endcase
  end

  // Output logic. Everything is derived from registered state, so the
  // stream outputs stay stable while stalled and clear with reset at once.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    bus.dump_busy = 1'b0;
    if (r_state == S_SEND) begin
      bus.out_valid = 1'b1;
      bus.dump_busy = 1'b1;
      bus.out_data  = w_image[r_index];
      bus.out_last  = (r_index == LAST_WORD);
    end
  end

endmodule

// File: tb/tb_optimsoc_config_readback.sv
// ---------------------------------------------------------------------------
// tb_optimsoc_config_readback
//
// Scoreboard bench: stimulus tasks push expected bus responses and stream
// words into queues; two monitors pop and compare whenever the DUT presents
// a bus response or a stream handshake.
// ---------------------------------------------------------------------------
module tb_optimsoc_config_readback;
  import optimsoc_config_pkg::*;

  function automatic config_t tb_cfg();
    config_t c;
    c = '0;
    c.NUMTILES        = 32'd4;
    c.NUMCTS          = 32'd4;
    c.CORES_PER_TILE  = 32'd2;
    c.GMEM_SIZE       = 32'h0100_0000;
    c.GMEM_TILE       = 32'd7;
    c.LMEM_SIZE       = 32'h0080_0000;
    c.LMEM_STYLE      = PLAIN;
    c.ENABLE_DM       = 1'b1;
    c.DM_BASE         = 32'h8000_0000;
    c.DM_SIZE         = 32'h0010_0000;
    c.PGAS_BASE       = 32'h4000_0000;
    c.PGAS_SIZE       = 32'h0020_0000;
    c.NA_DMA_ENTRIES  = 32'd4;
    c.USE_DEBUG       = 1'b1;
    c.DEBUG_CTM       = 1'b1;
    c.DEBUG_NUM_MODS  = 32'd3;
    c.TOTAL_NUM_CORES = 32'd8;
    for (int j = 0; j < 64; j++) c.CTLIST[j] = 16'(2 * j);
    return c;
  endfunction

  localparam config_t TB_CFG = tb_cfg();

  // Hand-computed register image for TB_CFG with TILEID=3.
  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    case (k)
      0:  w = 32'h0000_0001;
      1:  w = 32'd3;
      2:  w = 32'd4;
      3:  w = 32'd4;
      4:  w = 32'd2;
      5:  w = 32'h0100_0000;
      6:  w = 32'd7;
      7:  w = 32'h0080_0000;
      8:  w = 32'd8;
      9:  w = 32'h0000_0684;
      10: w = 32'h8000_0000;
      11: w = 32'h0010_0000;
      12: w = 32'h4000_0000;
      13: w = 32'h0020_0000;
      14: w = 32'd4;
      15: w = 32'd3;
      default: begin
        // CTLIST[j]=2j, so word 32+k = {4k+2, 4k}
        if (k >= 32) w = {16'(4 * (k - 32) + 2), 16'(4 * (k - 32))};
        else         w = 32'd0;
      end
    endcase
    return w;
  endfunction

  logic clk;
  logic rst;

  optimsoc_config_readback_if u_if ();

  optimsoc_config_readback #(
    .CONFIG (TB_CFG),
    .TILEID (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        err;
    logic [7:0]  adr;
    logic [31:0] data;
  } bus_exp_t;

  typedef struct packed {
    logic        last;
    logic [5:0]  idx;
    logic [31:0] data;
  } str_exp_t;

  bus_exp_t bus_q[$];
  str_exp_t str_q[$];

  // ---------------- bus monitor ----------------
  bus_exp_t mon_b;
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.wb_ack_o || u_if.wb_err_o) begin
        check("ack_err_exclusive", 32'(u_if.wb_ack_o & u_if.wb_err_o), 32'd0);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: ack=%0b err=%0b dat=0x%08h, required no response",
                   u_if.wb_ack_o, u_if.wb_err_o, u_if.wb_dat_o);
        end else begin
          mon_b = bus_q.pop_front();
          check($sformatf("bus_err@%02h", mon_b.adr), 32'(u_if.wb_err_o), 32'(mon_b.err));
          check($sformatf("bus_ack@%02h", mon_b.adr), 32'(u_if.wb_ack_o), 32'(!mon_b.err));
          check($sformatf("bus_dat@%02h", mon_b.adr), u_if.wb_dat_o, mon_b.data);
          $display("bus %s adr=0x%02h dat=0x%08h", mon_b.err ? "err" : "ack",
                   mon_b.adr, u_if.wb_dat_o);
        end
      end else begin
        check("bus_dat_idle", u_if.wb_dat_o, 32'd0);
      end
    end
  end

  // ---------------- stream monitor ----------------
  str_exp_t    mon_s;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  int          str_words  = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(u_if.out_valid), 32'd1);
        check("stall_data", u_if.out_data, prev_data);
        check("stall_last", 32'(u_if.out_last), 32'(prev_last));
      end
      if (u_if.out_valid && u_if.out_ready) begin
        if (str_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected: data=0x%08h, required no word", u_if.out_data);
        end else begin
          mon_s = str_q.pop_front();
          check($sformatf("stream_data[%0d]", mon_s.idx), u_if.out_data, mon_s.data);
          check($sformatf("stream_last[%0d]", mon_s.idx), 32'(u_if.out_last), 32'(mon_s.last));
          $display("stream word %0d data=0x%08h last=%0b", mon_s.idx, u_if.out_data, u_if.out_last);
        end
        str_words++;
      end
      prev_stall = u_if.out_valid && !u_if.out_ready;
      prev_data  = u_if.out_data;
      prev_last  = u_if.out_last;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic bus_xfer(input logic [7:0] adr, input logic we, input logic [31:0] exp);
    @(posedge clk); #1;
    bus_q.push_back('{err: we, adr: adr, data: exp});
    u_if.wb_cyc_i = 1'b1;
    u_if.wb_stb_i = 1'b1;
    u_if.wb_we_i  = we;
    u_if.wb_adr_i = adr;
    @(posedge clk); #1;
    // response must be up exactly one edge after the strobe was sampled
    check($sformatf("latency_ack@%02h", adr), 32'(u_if.wb_ack_o), 32'(!we));
    check($sformatf("latency_err@%02h", adr), 32'(u_if.wb_err_o), 32'(we));
    u_if.wb_cyc_i = 1'b0;
    u_if.wb_stb_i = 1'b0;
    u_if.wb_we_i  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(u_if.wb_ack_o),  32'd0);
    check({tag, "_err"},   32'(u_if.wb_err_o),  32'd0);
    check({tag, "_dat"},   u_if.wb_dat_o,       32'd0);
    check({tag, "_valid"}, 32'(u_if.out_valid), 32'd0);
    check({tag, "_last"},  32'(u_if.out_last),  32'd0);
    check({tag, "_data"},  u_if.out_data,       32'd0);
    check({tag, "_busy"},  32'(u_if.dump_busy), 32'd0);
  endtask

  task automatic start_dump();
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++)
      str_q.push_back('{last: (k == 63), idx: 6'(k), data: exp_word(k)});
    u_if.dump_start = 1'b1;
    @(posedge clk); #1;
    u_if.dump_start = 1'b0;
    check("dump_first_valid", 32'(u_if.out_valid), 32'd1);
    check("dump_first_data", u_if.out_data, 32'h0000_0001);
    check("dump_first_busy", 32'(u_if.dump_busy), 32'd1);
  endtask

  // Runs a started dump with out_ready=1 and pulses dump_start on the
  // final handshake edge, which must be ignored.
  task automatic finish_dump_ready(input string tag);
    int  n;
    bit  done;
    n    = 1;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (u_if.out_last) u_if.dump_start = 1'b1;
      @(posedge clk); #1;
      if (u_if.out_valid) n++;
      else begin
        done = 1'b1;
        break;
      end
    end
    u_if.dump_start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_valid_cycles"}, 32'(n), 32'd64);
    check({tag, "_busy_after"}, 32'(u_if.dump_busy), 32'd0);
    check({tag, "_last_after"}, 32'(u_if.out_last), 32'd0);
    @(posedge clk); #1;
    check({tag, "_start_on_last_ignored"}, 32'(u_if.out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  w0;
  bit  bp_done;

  initial begin
    rst             = 1'b1;
    u_if.wb_cyc_i   = 1'b0;
    u_if.wb_stb_i   = 1'b0;
    u_if.wb_we_i    = 1'b0;
    u_if.wb_adr_i   = '0;
    u_if.dump_start = 1'b0;
    u_if.out_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst = 1'b0;

    // ---- bus reads ----
    bus_xfer(8'h00, 1'b0, 32'h0000_0001);
    bus_xfer(8'h04, 1'b0, 32'd3);
    bus_xfer(8'h08, 1'b0, 32'd4);
    bus_xfer(8'h20, 1'b0, 32'd8);
    bus_xfer(8'h24, 1'b0, 32'h0000_0684);
    bus_xfer(8'h80, 1'b0, 32'h0002_0000);
    bus_xfer(8'h40, 1'b0, 32'd0);
    bus_xfer(8'h14, 1'b0, 32'h0100_0000);
    bus_xfer(8'hFC, 1'b0, 32'h007E_007C);
    bus_xfer(8'h2B, 1'b0, 32'h8000_0000);  // byte bits ignored

    // ---- write rejection ----
    bus_xfer(8'h08, 1'b1, 32'd0);
    bus_xfer(8'h08, 1'b0, 32'd4);

    // ---- strobe dropped before the edge: no response ----
    @(posedge clk); #1;
    u_if.wb_adr_i = 8'h0C;
    u_if.wb_cyc_i = 1'b1;
    u_if.wb_stb_i = 1'b1;
    #3;
    u_if.wb_stb_i = 1'b0;
    u_if.wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    check("abort_no_ack", 32'(u_if.wb_ack_o), 32'd0);
    check("abort_no_err", 32'(u_if.wb_err_o), 32'd0);

    // ---- held strobe for 4 edges: exactly two acks ----
    @(posedge clk); #1;
    bus_q.push_back('{err: 1'b0, adr: 8'h0C, data: 32'd4});
    bus_q.push_back('{err: 1'b0, adr: 8'h0C, data: 32'd4});
    u_if.wb_adr_i = 8'h0C;
    u_if.wb_cyc_i = 1'b1;
    u_if.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("held_ack_1", 32'(u_if.wb_ack_o), 32'd1);
    @(posedge clk); #1;
    check("held_gap", 32'(u_if.wb_ack_o), 32'd0);
    @(posedge clk); #1;
    check("held_ack_2", 32'(u_if.wb_ack_o), 32'd1);
    @(posedge clk); #1;
    u_if.wb_cyc_i = 1'b0;
    u_if.wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_acks_consumed", 32'(bus_q.size()), 32'd0);

    // ---- full dump, out_ready tied high ----
    u_if.out_ready = 1'b1;
    w0 = str_words;
    start_dump();
    finish_dump_ready("dump_ready");
    check("dump_ready_words", 32'(str_words - w0), 32'd64);

    // ---- backpressure, second dump_start mid-dump ----
    u_if.out_ready = 1'b0;
    w0 = str_words;
    bp_done = 1'b0;
    start_dump();
    for (int it = 0; it < 2000; it++) begin
      @(posedge clk); #1;
      if (!u_if.dump_busy) begin
        bp_done = 1'b1;
        break;
      end
      u_if.out_ready  = 1'($urandom_range(0, 1));
      u_if.dump_start = (it == 10);
    end
    u_if.dump_start = 1'b0;
    check("bp_done", 32'(bp_done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_words", 32'(str_words - w0), 32'd64);
    check("bp_no_restart", 32'(u_if.out_valid), 32'd0);

    // ---- reset during word 20 of a dump ----
    u_if.out_ready = 1'b1;
    start_dump();
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_word20", u_if.out_data, exp_word(20));
    rst = 1'b1;
    str_q.delete();
    #1;
    check_all_zero("rst_dump");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_word", 32'(u_if.out_valid), 32'd0);

    // ---- reset during a pending bus ack ----
    @(posedge clk); #1;
    u_if.wb_adr_i = 8'h04;
    u_if.wb_cyc_i = 1'b1;
    u_if.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("pending_ack", 32'(u_if.wb_ack_o), 32'd1);
    rst = 1'b1;
    u_if.wb_cyc_i = 1'b0;
    u_if.wb_stb_i = 1'b0;
    #1;
    check_all_zero("rst_bus");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_ack", 32'(u_if.wb_ack_o), 32'd0);

    // ---- fresh dump after reset starts at word 0 ----
    w0 = str_words;
    start_dump();
    finish_dump_ready("dump_fresh");
    check("dump_fresh_words", 32'(str_words - w0), 32'd64);
    bus_xfer(8'h08, 1'b0, 32'd4);

    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    check("stream_queue_empty", 32'(str_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/optimsoc_config_readback.md
# optimsoc_config_readback

Read-only responder for the static system configuration: takes the derived `config_t` struct as a parameter and exposes it to software as a word-addressed register file on a Wishbone slave port. It also exposes it to the debug infrastructure as a 64-word burst on a valid/ready stream. It sits in each compute tile next to the network adapter, so software and host tools can discover the tile count, memory map and feature flags at runtime.

## Interface
- `CONFIG`, default `'x`: derived `config_t` configuration (the struct, not the base struct).
- `TILEID`, default 0: tile index reported at register 0x04.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `wb_cyc_i`, in, 1: Wishbone cycle.
- `wb_stb_i`, in, 1: Wishbone strobe.
- `wb_we_i`, in, 1: write enable. Writes are rejected.
- `wb_adr_i`, in, 8: byte address. Bits [7:2] select the word; bits [1:0] are ignored.
- `wb_dat_o`, out, 32: read data.
- `wb_ack_o`, out, 1: read acknowledge.
- `wb_err_o`, out, 1: error acknowledge.
- `dump_start`, in, 1: single-cycle request to stream the full register image.
- `dump_busy`, out, 1: a dump is in progress.
- `out_valid`, out, 1: stream word valid.
- `out_ready`, in, 1: stream sink ready.
- `out_data`, out, 32: stream word.
- `out_last`, out, 1: marks word 63.

## Operation
Register map (word offset, 32-bit, zero-extended):
- Words 0x00–0x0C: 0x00 VERSION = 0x0000_0001; 0x04 TILEID; 0x08 NUMTILES; 0x0C NUMCTS.
- Words 0x10–0x20: 0x10 CORES_PER_TILE; 0x14 GMEM_SIZE; 0x18 GMEM_TILE; 0x1C LMEM_SIZE; 0x20 TOTAL_NUM_CORES.
- 0x24 FLAGS:
  - [0] NOC_ENABLE_VCHANNELS, [1] ENABLE_BOOTROM, [2] ENABLE_DM, [3] ENABLE_PGAS.
  - [4] NA_ENABLE_MPSIMPLE, [5] NA_ENABLE_DMA, [6] NA_DMA_GENIRQ.
  - [7] USE_DEBUG, [8] DEBUG_STM, [9] DEBUG_CTM.
  - [10] LMEM_STYLE==PLAIN.
  - [31:11] read as 0.
- Words 0x28–0x3C: 0x28 DM_BASE; 0x2C DM_SIZE; 0x30 PGAS_BASE; 0x34 PGAS_SIZE; 0x38 NA_DMA_ENTRIES; 0x3C DEBUG_NUM_MODS.
- 0x40–0x7C: reserved, read 0.
- 0x80–0xFC: CTLIST, word k (k = 0..31) = {CTLIST[2k+1], CTLIST[2k]}.
- The register image is a pure function of the word index. The bus port and the stream port share the decode function but run independently and concurrently.

Wishbone responder:
- Read (we=0) to any word → `wb_ack_o`, with the decoded data.
- Write (we=1) to any word → `wb_err_o`, with `wb_dat_o`=0. No state changes.

Dump state machine, states IDLE and SEND:
- IDLE → SEND when `dump_start`=1. The 6-bit index is set to 0.
- In SEND, `out_valid`=1, `out_data`=image[index], `out_last`=(index==63).
- On `out_valid & out_ready`: if index==63, go to IDLE; otherwise index+1.
- The index never wraps past 63 within a dump.
- `dump_start` is ignored in SEND. `dump_busy` = (state==SEND).

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, state IDLE, index 0, `out_valid`=0, `out_last`=0, `out_data`=0, `dump_busy`=0.
- Bus latency is one cycle:
  - cyc&stb sampled high at edge N with ack/err low → `wb_ack_o` (or `wb_err_o`) high for exactly the cycle after edge N, with registered `wb_dat_o`.
  - The next edge clears ack/err. A held strobe therefore yields ack on alternate cycles; there are no back-to-back acks.
- `wb_ack_o` and `wb_err_o` are never high together.
- `wb_dat_o` returns to 0 when no ack is high.
- If cyc or stb drops before the ack edge, no ack or err is produced.
- `dump_start` at edge N → `out_valid`=1 with word 0 after edge N.
- Throughput is one word per cycle while `out_ready`=1, so the full dump takes 64 cycles minimum.
- While `out_valid & !out_ready`, `out_data`, `out_last` and `out_valid` are held stable.
- After the last handshake at edge M, `out_valid`, `out_last` and `dump_busy` are 0 after edge M.
- A new `dump_start` is accepted at edge M+1 or later. A `dump_start` coinciding with the last handshake edge is ignored.
- Asserting `rst` mid-bus-cycle or mid-dump forces all outputs to their reset values immediately, without waiting for a clock edge. No partial word is emitted after reset release.

## Test plan
- Bus reads: CONFIG with NUMTILES=4, NUMCTS=4, CORES_PER_TILE=2, TILEID=3. Read 0x00, 0x04, 0x08, 0x20 → 0x1, 0x3, 0x4, 0x8, each with ack exactly one cycle after strobe.
- FLAGS and CTLIST:
  - ENABLE_DM=1, USE_DEBUG=1, DEBUG_CTM=1, LMEM_STYLE=PLAIN. Read 0x24 → 0x0000_0684.
  - CTLIST[0]=0, CTLIST[1]=2. Read 0x80 → 0x0002_0000.
  - Read 0x40 → 0.
- Write rejection: write 0xDEAD_BEEF to 0x08 → `wb_err_o` high one cycle, no ack. A subsequent read of 0x08 still returns NUMTILES.
- Dump with `out_ready` tied 1: pulse `dump_start` → 64 consecutive valid words matching bus reads of 0x00..0xFC. `out_last` on word 63 only. `dump_busy` low the cycle after.
- Backpressure: toggle `out_ready` pseudo-randomly → data stable during stalls, no word lost or duplicated. A second `dump_start` mid-dump is ignored, and exactly 64 words are seen.
- Reset: assert `rst` during word 20 of a dump and during a pending bus ack → outputs go to 0 asynchronously. After release, the first word of a fresh dump is word 0.
